// File: rtl/fr_stage_pkg.sv
// Shared definitions for the fr_stage pipeline register:
// occupancy encoding, default address width and per-stage payload widths.
package fr_stage_pkg;

  typedef enum logic [1:0] {
    FR_EMPTY = 2'd0,
    FR_ONE   = 2'd1,
    FR_FULL  = 2'd2
  } fr_state_e;

  localparam int FR_ADDR_W = 32;

  localparam int FR_FD_W = 64;
  localparam int FR_DE_W = 118;
  localparam int FR_EM_W = 76;
  // alu result + mem rdata + rd + reg_we + mem_to_reg
  localparam int FR_MW_W = 32 + 32 + 5 + 1 + 1;

endpackage

// File: rtl/fr_stage_slot.sv
// Single valid + payload + address register with load and clear.
// Clearing zeroes the payload only when CLEAR_BUBBLE is set.
module fr_stage_slot #(
  parameter int WIDTH        = 64,
  parameter int ADDR_WIDTH   = 32,
  parameter bit CLEAR_BUBBLE = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld_i,
  input  logic                  clr_i,
  input  logic [WIDTH-1:0]      data_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  valid_o,
  output logic [WIDTH-1:0]      data_o,
  output logic [ADDR_WIDTH-1:0] addr_o
);

  logic                  valid_q;
  logic [WIDTH-1:0]      data_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
      if (CLEAR_BUBBLE) begin
        data_q <= '0;
        addr_q <= '0;
      end
    end else if (ld_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      addr_q  <= addr_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign addr_o  = addr_q;

endmodule

// File: rtl/fr_stage.sv
// Valid/ready pipeline stage register with two-entry skid and flush.
// Optional FR_STAGE_PERF_EN adds stall/bubble counters.
module fr_stage
  import fr_stage_pkg::*;
#(
  parameter int WIDTH        = 64,
  parameter int ADDR_WIDTH   = FR_ADDR_W,
  parameter bit CLEAR_BUBBLE = 1'b1
) (
  input  logic                  clk,
  input  logic                  RESET_N,
  input  logic                  FLUSH,
  input  logic                  D_valid,
  output logic                  D_ready,
  input  logic [WIDTH-1:0]      D_data,
  input  logic [ADDR_WIDTH-1:0] D_Exam_InstrAddr,
  output logic                  Q_valid,
  input  logic                  Q_ready,
  output logic [WIDTH-1:0]      Q_data,
  output logic [ADDR_WIDTH-1:0] Q_Exam_InstrAddr
`ifdef FR_STAGE_PERF_EN
  ,
  output logic [31:0]           Q_stall_cnt,
  output logic [31:0]           Q_bubble_cnt
`endif
);

  fr_state_e state, state_d;

  logic                  skid_v;
  logic [WIDTH-1:0]      skid_data;
  logic [ADDR_WIDTH-1:0] skid_addr;

  logic                  main_ld, main_clr, from_skid;
  logic                  skid_ld, skid_clr;
  logic [WIDTH-1:0]      main_data_d;
  logic [ADDR_WIDTH-1:0] main_addr_d;
  logic                  in_hs, out_hs;
  logic                  ready_q, ready_d;

  // occupancy lives in the two slot valid flops
  assign state = skid_v  ? FR_FULL :
                 Q_valid ? FR_ONE  : FR_EMPTY;

  assign in_hs  = D_valid & ready_q;
  assign out_hs = Q_valid & Q_ready;

  always_comb begin
    state_d   = state;
    main_ld   = 1'b0;
    main_clr  = 1'b0;
    from_skid = 1'b0;
    skid_ld   = 1'b0;
    skid_clr  = 1'b0;
    if (FLUSH) begin
      state_d  = FR_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      unique case (state)
        FR_EMPTY: begin
          if (in_hs) begin
            state_d = FR_ONE;
            main_ld = 1'b1;
          end
        end
        FR_ONE: begin
          if (in_hs && out_hs) begin
            main_ld = 1'b1;
          end else if (in_hs) begin
            state_d = FR_FULL;
            skid_ld = 1'b1;
          end else if (out_hs) begin
            state_d  = FR_EMPTY;
            main_clr = 1'b1;
          end
        end
        FR_FULL: begin
          if (out_hs) begin
            state_d   = FR_ONE;
            main_ld   = 1'b1;
            from_skid = 1'b1;
            skid_clr  = 1'b1;
          end
        end
        default: begin
          state_d  = FR_EMPTY;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  assign main_data_d = from_skid ? skid_data : D_data;
  assign main_addr_d = from_skid ? skid_addr : D_Exam_InstrAddr;
  assign ready_d     = (state_d != FR_FULL);

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) ready_q <= 1'b0;
    else          ready_q <= ready_d;
  end

  assign D_ready = ready_q;

  fr_stage_slot #(
    .WIDTH       (WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .CLEAR_BUBBLE(CLEAR_BUBBLE)
  ) u_main (
    .clk    (clk),
    .rst_n  (RESET_N),
    .ld_i   (main_ld),
    .clr_i  (main_clr),
    .data_i (main_data_d),
    .addr_i (main_addr_d),
    .valid_o(Q_valid),
    .data_o (Q_data),
    .addr_o (Q_Exam_InstrAddr)
  );

  fr_stage_slot #(
    .WIDTH       (WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .CLEAR_BUBBLE(CLEAR_BUBBLE)
  ) u_skid (
    .clk    (clk),
    .rst_n  (RESET_N),
    .ld_i   (skid_ld),
    .clr_i  (skid_clr),
    .data_i (D_data),
    .addr_i (D_Exam_InstrAddr),
    .valid_o(skid_v),
    .data_o (skid_data),
    .addr_o (skid_addr)
  );

`ifdef FR_STAGE_PERF_EN
  logic [31:0] stall_q, bubble_q;

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (Q_valid && !Q_ready && stall_q != 32'hFFFF_FFFF)
        stall_q <= stall_q + 32'd1;
      if (!Q_valid && bubble_q != 32'hFFFF_FFFF)
        bubble_q <= bubble_q + 32'd1;
    end
  end

  assign Q_stall_cnt  = stall_q;
  assign Q_bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_fr_stage.sv
// Randomised self-checking bench for fr_stage against a queue model.
// Directed phases pin reset, streaming, backpressure, flush, async reset.
module tb_fr_stage;

  localparam int W  = 64;
  localparam int AW = 32;

  logic          clk;
  logic          RESET_N;
  logic          FLUSH;
  logic          D_valid;
  logic          D_ready;
  logic [W-1:0]  D_data;
  logic [AW-1:0] D_Exam_InstrAddr;
  logic          Q_valid;
  logic          Q_ready;
  logic [W-1:0]  Q_data;
  logic [AW-1:0] Q_Exam_InstrAddr;
`ifdef FR_STAGE_PERF_EN
  logic [31:0]   Q_stall_cnt;
  logic [31:0]   Q_bubble_cnt;
`endif

  int checks = 0;
  int errors = 0;

  fr_stage #(.WIDTH(W), .ADDR_WIDTH(AW), .CLEAR_BUBBLE(1'b1)) dut (
    .clk             (clk),
    .RESET_N         (RESET_N),
    .FLUSH           (FLUSH),
    .D_valid         (D_valid),
    .D_ready         (D_ready),
    .D_data          (D_data),
    .D_Exam_InstrAddr(D_Exam_InstrAddr),
    .Q_valid         (Q_valid),
    .Q_ready         (Q_ready),
    .Q_data          (Q_data),
    .Q_Exam_InstrAddr(Q_Exam_InstrAddr)
`ifdef FR_STAGE_PERF_EN
    ,
    .Q_stall_cnt     (Q_stall_cnt),
    .Q_bubble_cnt    (Q_bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the stage is a FIFO of at most two beats; ready is registered.
  logic [W-1:0]  mq_d[$];
  logic [AW-1:0] mq_a[$];
  bit            m_rdy;

  always @(posedge clk or negedge RESET_N) begin : model
    bit in_b, out_b;
    if (!RESET_N) begin
      mq_d.delete();
      mq_a.delete();
      m_rdy = 1'b0;
    end else begin
      in_b  = D_valid && m_rdy;
      out_b = (mq_d.size() > 0) && Q_ready;
      if (FLUSH) begin
        mq_d.delete();
        mq_a.delete();
      end else begin
        if (out_b) begin
          void'(mq_d.pop_front());
          void'(mq_a.pop_front());
        end
        if (in_b) begin
          mq_d.push_back(D_data);
          mq_a.push_back(D_Exam_InstrAddr);
        end
      end
      m_rdy = (mq_d.size() < 2);
    end
  end

  always @(negedge clk) begin
    logic [W-1:0]  ed;
    logic [AW-1:0] ea;
    ed = (mq_d.size() > 0) ? mq_d[0] : '0;
    ea = (mq_a.size() > 0) ? mq_a[0] : '0;
    chk("m_valid", 64'(Q_valid), 64'(mq_d.size() > 0));
    chk("m_ready", 64'(D_ready), 64'(m_rdy));
    chk("m_data",  Q_data, ed);
    chk("m_addr",  64'(Q_Exam_InstrAddr), 64'(ea));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d);
    D_valid          = 1'b1;
    D_data           = d;
    D_Exam_InstrAddr = AW'(32'h400 + d[15:0] * 4);
    step();
  endtask

  initial begin
    RESET_N = 1'b0; FLUSH = 1'b0; Q_ready = 1'b1;
    D_valid = 1'b1; D_data = 64'h1; D_Exam_InstrAddr = 32'h404;
    repeat (3) step();
    chk("rst_qvalid", 64'(Q_valid), 64'h0);
    chk("rst_qdata",  Q_data, 64'h0);
    chk("rst_dready", 64'(D_ready), 64'h0);
    RESET_N = 1'b1;
    step();
    chk("rel_dready", 64'(D_ready), 64'h1);
    chk("rel_qvalid", 64'(Q_valid), 64'h0);
    step();
    D_valid = 1'b0;
    chk("first_qvalid", 64'(Q_valid), 64'h1);
    chk("first_qdata",  Q_data, 64'h1);
    step();

    for (int i = 0; i < 16; i++) begin
      send(64'(32'h10 + i));
      chk("stream_data",  Q_data, 64'(32'h10 + i));
      chk("stream_ready", 64'(D_ready), 64'h1);
    end
    D_valid = 1'b0;
    step();

    Q_ready = 1'b0;
    send(64'hA);
    send(64'hB);
    D_valid = 1'b0;
    step();
    chk("bp_ready", 64'(D_ready), 64'h0);
    chk("bp_data",  Q_data, 64'hA);
    chk("bp_valid", 64'(Q_valid), 64'h1);
    Q_ready = 1'b1;
    step();
    chk("bp_next",  Q_data, 64'hB);
    chk("bp_ready2", 64'(D_ready), 64'h1);
    step();
    chk("bp_drain", 64'(Q_valid), 64'h0);

    Q_ready = 1'b0;
    send(64'hA);
    send(64'hB);
    FLUSH = 1'b1;
    send(64'hC);
    FLUSH = 1'b0;
    D_valid = 1'b0;
    chk("fl_valid", 64'(Q_valid), 64'h0);
    chk("fl_data",  Q_data, 64'h0);
    chk("fl_ready", 64'(D_ready), 64'h1);
    Q_ready = 1'b1;
    step();
    chk("fl_noC", 64'(Q_valid), 64'h0);

    Q_ready = 1'b0;
    send(64'hA);
    send(64'hB);
    D_valid = 1'b0;
    #1 RESET_N = 1'b0;
    #1;
    chk("ar_valid", 64'(Q_valid), 64'h0);
    chk("ar_data",  Q_data, 64'h0);
    chk("ar_ready", 64'(D_ready), 64'h0);
    step();
    RESET_N = 1'b1;
    step();

    for (int i = 0; i < 3000; i++) begin
      D_valid          = ($urandom_range(0, 3) != 0);
      D_data           = {$urandom(), $urandom()};
      D_Exam_InstrAddr = $urandom();
      Q_ready          = ($urandom_range(0, 2) != 0);
      FLUSH            = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 255) == 0) begin
        RESET_N = 1'b0;
        step();
        RESET_N = 1'b1;
      end
      step();
    end
    FLUSH = 1'b0;
    D_valid = 1'b0;

`ifdef FR_STAGE_PERF_EN
    RESET_N = 1'b0;
    Q_ready = 1'b0;
    step();
    RESET_N = 1'b1;
    step();
    send(64'h55);
    D_valid = 1'b0;
    repeat (5) step();
    chk("perf_stall",  64'(Q_stall_cnt), 64'd5);
    chk("perf_bubble", 64'(Q_bubble_cnt), 64'd2);
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    chk("perf_keep", 64'(Q_stall_cnt), 64'd6);
`endif

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
